// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode slice of the core.
//   INSTR_W, OPC_W    : instruction word and opcode field widths
//   OPC_*             : major opcodes recognised by the control decoder
//   fetchState_t      : fetch sequencer states
//   opcodeOf()        : extracts the opcode field from an instruction word
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetchState_t;

    function automatic logic [OPC_W-1:0] opcodeOf(input logic [INSTR_W-1:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used both as the fetched-instruction buffer and as the
// in-order request-PC tag queue.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; wins over push/pop in the same cycle
//   push       : write pushData (accepted when not full, or when full and popping)
//   pop        : retire the head entry (ignored when empty)
//   headData   : current head entry (stale contents when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign doPop    = pop && !empty;
    // A full FIFO may still take a write when the head leaves in the same cycle.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch stage feeding the control decoder.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : word-aligned fetch requests to instruction memory
//   imem_rsp_valid/data            : in-order responses, no backpressure
//   branch_taken/target            : single-cycle redirect from branch resolution
//   instr_valid/ready              : decode handshake on the buffer head
//   instr, instr_pc, opCode        : head instruction, its PC and opcode field (0 when empty)
//
// state | meaning
// IDLE  | first cycle after reset, no requests
// RUN   | fetching, every response is kept
// FLUSH | dropping responses of requests issued before the last redirect
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [OPC_W-1:0]    opCode
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W+1)'(DEPTH);

    fetchState_t                 state;
    fetchState_t                 stateNext;
    logic [ADDR_W-1:0]           pc;
    logic [CNT_W-1:0]            discardCnt;
    logic [CNT_W-1:0]            discardNext;
    logic [CNT_W-1:0]            outstanding;
    logic [CNT_W-1:0]            bufCount;
    logic                        tagEmpty;
    logic                        bufEmpty;
    logic [ADDR_W-1:0]           reqPcHead;
    logic [ADDR_W+INSTR_W-1:0]   bufHead;
    logic [ADDR_W-1:0]           headPc;
    logic [INSTR_W-1:0]          headInstr;
    logic                        credit;
    logic                        reqFire;
    logic                        rspAccept;
    logic                        keepRsp;
    logic                        popHead;
    logic                        unusedFull;
    logic                        tagFull;
    logic                        bufFull;

    // The tag queue holds one PC per request in flight, so its count is the
    // outstanding-request count and nothing else needs to track it.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tagQueue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (reqFire),
        .pop      (rspAccept),
        .pushData (pc),
        .headData (reqPcHead),
        .full     (tagFull),
        .empty    (tagEmpty),
        .count    (outstanding)
    );

    fetch_fifo #(.WIDTH(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_instrBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (branch_taken),
        .push     (keepRsp),
        .pop      (popHead),
        .pushData ({reqPcHead, imem_rsp_data}),
        .headData (bufHead),
        .full     (bufFull),
        .empty    (bufEmpty),
        .count    (bufCount)
    );

    // Credit keeps in-flight plus buffered entries within the buffer size,
    // which is what guarantees a response never lands on a full buffer.
    assign unusedFull     = tagFull | bufFull;
    assign credit         = ({1'b0, outstanding} + {1'b0, bufCount}) < DEPTH_CNT;
    assign imem_req_valid = (state != IDLE) && credit && !branch_taken;
    assign imem_req_addr  = pc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight (stale traffic after a reset) are ignored.
    assign rspAccept = imem_rsp_valid && !tagEmpty;
    assign keepRsp   = rspAccept && (discardCnt == '0) && !branch_taken;
    assign popHead   = instr_valid && instr_ready && !branch_taken;

    assign {headPc, headInstr} = bufHead;
    assign instr_valid = !bufEmpty;
    assign instr       = bufEmpty ? '0 : headInstr;
    assign instr_pc    = bufEmpty ? '0 : headPc;
    assign opCode      = opcodeOf(instr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            discardCnt <= '0;
        end else begin
            state      <= stateNext;
            discardCnt <= discardNext;
            if (branch_taken)
                pc <= {branch_target[ADDR_W-1:2], 2'b00};
            else if (reqFire)
                pc <= pc + ADDR_W'(4);
        end
    end

    // On a redirect every request still in flight belongs to the old path,
    // less the one retiring this cycle (which is dropped here directly).
    always_comb begin
        stateNext   = state;
        discardNext = discardCnt;
        if (branch_taken)
            discardNext = outstanding - {{(CNT_W-1){1'b0}}, rspAccept};
        else if (rspAccept && (discardCnt != '0))
            discardNext = discardCnt - 1'b1;

        case (state)
            IDLE:    stateNext = RUN;
            RUN:     if (branch_taken && (discardNext != '0)) stateNext = FLUSH;
            FLUSH:   if (discardNext == '0) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opCode;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opCode         (opCode)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    int          asserts = 0;
    int          failures = 0;
    int          cyc = 0;
    memReq_t     memQ[$];
    // Architectural model: program order restarts at each redirect target.
    logic [31:0] expReqPc;
    logic [31:0] expPopPc;
    int          popCount = 0;

    bit          reqRdyRandom, reqRdyFixed, instrRdyRandom, instrRdyFixed, rspEnable;
    int          latMin, latMax;

    logic        lastReqValid, lastReqFire, lastRspDriven, lastInstrValid, lastPop;
    logic [31:0] lastReqAddr, lastRspAddr, lastInstrPc, lastInstr;
    logic [5:0]  lastOpc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [5:0] opc;
        case (a[3:2])
            2'd0:    opc = 6'b100011;
            2'd1:    opc = 6'b101011;
            2'd2:    opc = 6'b000100;
            default: opc = 6'b000000;
        endcase
        return {opc, a[25:0]};
    endfunction

    task automatic setDefaults();
        reqRdyRandom   = 1'b0;
        reqRdyFixed    = 1'b1;
        instrRdyRandom = 1'b0;
        instrRdyFixed  = 1'b1;
        rspEnable      = 1'b1;
        latMin         = 1;
        latMax         = 1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        branch_taken   = 1'b0;
        branch_target  = '0;
        instr_ready    = 1'b0;
        memQ.delete();
        expReqPc = RESET_PC;
        expPopPc = RESET_PC;
        setDefaults();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus plus model checks; entered and left at a falling edge.
    task automatic cycle(input bit br, input logic [31:0] tgt);
        logic [31:0] headWord;
        int          lat;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        lastRspDriven  = 1'b0;
        if (rspEnable && memQ.size() > 0 && memQ[0].due <= cyc) begin
            lastRspDriven  = 1'b1;
            lastRspAddr    = memQ[0].addr;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end
        branch_taken   = br;
        branch_target  = tgt;
        imem_req_ready = reqRdyRandom ? ($urandom_range(0, 3) != 0) : reqRdyFixed;
        instr_ready    = instrRdyRandom ? ($urandom_range(0, 1) == 1) : instrRdyFixed;
        #1;
        lastReqValid   = imem_req_valid;
        lastReqFire    = imem_req_valid & imem_req_ready;
        lastReqAddr    = imem_req_addr;
        lastInstrValid = instr_valid;
        lastInstrPc    = instr_pc;
        lastInstr      = instr;
        lastOpc        = opCode;
        lastPop        = instr_valid & instr_ready & !br;

        if (!instr_valid) begin
            asserts++;
            if (instr !== 32'h0 || instr_pc !== 32'h0 || opCode !== 6'h0) begin
                failures++;
                $display("FAIL empty_outputs_zero cyc=%0d: instr=%h pc=%h opc=%b, required all 0", cyc, instr, instr_pc, opCode);
            end
        end else begin
            headWord = memWord(expPopPc);
            asserts++;
            if (instr_pc !== expPopPc || instr !== headWord || opCode !== headWord[31:26]) begin
                failures++;
                $display("FAIL head_contents cyc=%0d: pc=%h instr=%h opc=%b, required pc=%h instr=%h opc=%b",
                         cyc, instr_pc, instr, opCode, expPopPc, headWord, headWord[31:26]);
            end
        end
        if (br) begin
            asserts++;
            if (imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL no_req_on_redirect cyc=%0d: imem_req_valid=%b, required 0", cyc, imem_req_valid);
            end
        end
        if (lastReqFire) begin
            asserts++;
            if (imem_req_addr !== expReqPc) begin
                failures++;
                $display("FAIL req_addr cyc=%0d: got %h, required %h", cyc, imem_req_addr, expReqPc);
            end
            expReqPc = expReqPc + 32'd4;
            lat = $urandom_range(latMin, latMax);
            memQ.push_back('{imem_req_addr, cyc + lat});
        end
        if (lastPop) begin
            expPopPc = expPopPc + 32'd4;
            popCount++;
        end
        if (br) begin
            expReqPc = {tgt[31:2], 2'b00};
            expPopPc = {tgt[31:2], 2'b00};
        end
        asserts++;
        if (memQ.size() > DEPTH) begin
            failures++;
            $display("FAIL outstanding_bound cyc=%0d: in flight %0d, allowed at most %0d", cyc, memQ.size(), DEPTH);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic runUntilReq(input logic [31:0] addr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire && lastReqAddr == addr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic runUntilPop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0, 32'h0);
            if (lastPop) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        asserts++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || opCode !== 6'h0) begin
            failures++;
            $display("FAIL reset_outputs: req_valid=%b instr_valid=%b instr=%h pc=%h opc=%b, required all 0",
                     imem_req_valid, instr_valid, instr, instr_pc, opCode);
        end
        doReset();
        cycle(1'b0, 32'h0);
        asserts++;
        if (lastReqValid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_request: imem_req_valid=%b, required 0", lastReqValid);
        end
        cycle(1'b0, 32'h0);
        asserts++;
        if (lastReqFire !== 1'b1 || lastReqAddr !== RESET_PC) begin
            failures++;
            $display("FAIL first_request: fire=%b addr=%h, required 1 at %h", lastReqFire, lastReqAddr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] reqLog[$];
        bit          found;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire) reqLog.push_back(lastReqAddr);
            if (lastRspDriven) begin
                found = 1'b1;
                break;
            end
        end
        asserts++;
        if (!found) begin
            failures++;
            $display("FAIL seq_first_rsp: no response within 10 cycles, required one");
        end
        asserts++;
        if (lastInstrValid !== 1'b0) begin
            failures++;
            $display("FAIL seq_no_bypass: instr_valid=%b in response cycle, required 0", lastInstrValid);
        end
        cycle(1'b0, 32'h0);
        if (lastReqFire) reqLog.push_back(lastReqAddr);
        asserts++;
        if (lastInstrValid !== 1'b1 || lastInstrPc !== 32'h0 || lastInstr !== 32'h8C00_0000 || lastOpc !== 6'b100011) begin
            failures++;
            $display("FAIL seq_first_instr: valid=%b pc=%h instr=%h opc=%b, required 1 00000000 8c000000 100011",
                     lastInstrValid, lastInstrPc, lastInstr, lastOpc);
        end
        for (int i = 0; i < 20 && reqLog.size() < 3; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire) reqLog.push_back(lastReqAddr);
        end
        asserts++;
        if (reqLog.size() < 3) begin
            failures++;
            $display("FAIL seq_req_count: %0d requests, required 3", reqLog.size());
        end else if (reqLog[0] !== 32'h0 || reqLog[1] !== 32'h4 || reqLog[2] !== 32'h8) begin
            failures++;
            $display("FAIL seq_req_order: %h %h %h, required 0 4 8", reqLog[0], reqLog[1], reqLog[2]);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_backpressure();
        int nReq;
        bit ok;
        doReset();
        instrRdyFixed = 1'b0;
        nReq = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire) nReq++;
        end
        asserts++;
        if (nReq != 2 || lastReqValid !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: %0d requests, req_valid=%b, required 2 and 0", nReq, lastReqValid);
        end
        instrRdyFixed = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire) begin
                ok = 1'b1;
                break;
            end
        end
        asserts++;
        if (!ok || lastReqAddr !== 32'h8) begin
            failures++;
            $display("FAIL bp_resume: fired=%b addr=%h, required 1 at 00000008", ok, lastReqAddr);
        end
    endtask

    task automatic holdTwoOutstanding(output bit ok);
        bit okA;
        runUntilReq(32'hC, 40, okA);
        for (int i = 0; i < 10 && memQ.size() > 0; i++) cycle(1'b0, 32'h0);
        rspEnable = 1'b0;
        runUntilReq(32'h14, 10, ok);
        ok = ok & okA;
    endtask

    task automatic test_redirect();
        bit ok;
        doReset();
        holdTwoOutstanding(ok);
        asserts++;
        if (!ok || memQ.size() != 2) begin
            failures++;
            $display("FAIL redir_setup: reached=%b in flight=%0d, required 1 and 2", ok, memQ.size());
        end
        cycle(1'b1, 32'h40);
        rspEnable = 1'b1;
        runUntilPop(30, ok);
        asserts++;
        if (!ok || lastInstrPc !== 32'h40) begin
            failures++;
            $display("FAIL redir_first_pc: popped=%b pc=%h, required 1 at 00000040", ok, lastInstrPc);
        end
    endtask

    task automatic test_redirect_with_rsp();
        bit ok;
        doReset();
        runUntilReq(32'hC, 40, ok);
        cycle(1'b1, 32'h103);
        asserts++;
        if (!ok || lastRspDriven !== 1'b1 || lastRspAddr !== 32'hC) begin
            failures++;
            $display("FAIL redir_rsp_setup: reached=%b rsp=%b addr=%h, required 1 1 0000000c", ok, lastRspDriven, lastRspAddr);
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (lastReqFire) begin
                ok = 1'b1;
                break;
            end
        end
        asserts++;
        if (!ok || lastReqAddr !== 32'h100) begin
            failures++;
            $display("FAIL redir_rsp_next_req: fired=%b addr=%h, required 1 at 00000100", ok, lastReqAddr);
        end
        runUntilPop(20, ok);
        asserts++;
        if (!ok || lastInstrPc !== 32'h100) begin
            failures++;
            $display("FAIL redir_rsp_first_pc: popped=%b pc=%h, required 1 at 00000100", ok, lastInstrPc);
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        doReset();
        instrRdyFixed = 1'b0;
        runUntilReq(32'h4, 10, ok);
        rspEnable = 1'b0;
        asserts++;
        if (!ok || instr_valid !== 1'b1 || memQ.size() != 1) begin
            failures++;
            $display("FAIL rst_mid_setup: reached=%b instr_valid=%b in flight=%0d, required 1 1 1", ok, instr_valid, memQ.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        asserts++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || opCode !== 6'h0) begin
            failures++;
            $display("FAIL rst_mid_async: req_valid=%b instr_valid=%b instr=%h pc=%h opc=%b, required all 0",
                     imem_req_valid, instr_valid, instr, instr_pc, opCode);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expReqPc = RESET_PC;
        expPopPc = RESET_PC;
        rspEnable = 1'b1;
        instrRdyFixed = 1'b1;
        cycle(1'b0, 32'h0);
        asserts++;
        if (lastReqValid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle: imem_req_valid=%b, required 0", lastReqValid);
        end
        cycle(1'b0, 32'h0);
        asserts++;
        if (lastReqFire !== 1'b1 || lastReqAddr !== RESET_PC || lastInstrValid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_restart: fire=%b addr=%h instr_valid=%b, required 1 %h 0", lastReqFire, lastReqAddr, lastInstrValid, RESET_PC);
        end
        runUntilPop(20, ok);
        asserts++;
        if (!ok || lastInstrPc !== RESET_PC) begin
            failures++;
            $display("FAIL rst_mid_first_pc: popped=%b pc=%h, required 1 at %h", ok, lastInstrPc, RESET_PC);
        end
    endtask

    task automatic test_redirect_in_flush();
        bit ok;
        doReset();
        holdTwoOutstanding(ok);
        cycle(1'b1, 32'h40);
        rspEnable   = 1'b1;
        reqRdyFixed = 1'b0;
        cycle(1'b0, 32'h0);
        asserts++;
        if (!ok || lastRspDriven !== 1'b1 || memQ.size() != 1) begin
            failures++;
            $display("FAIL flush_setup: reached=%b rsp=%b in flight=%0d, required 1 1 1", ok, lastRspDriven, memQ.size());
        end
        rspEnable   = 1'b0;
        reqRdyFixed = 1'b1;
        cycle(1'b1, 32'h200);
        rspEnable = 1'b1;
        runUntilPop(30, ok);
        asserts++;
        if (!ok || lastInstrPc !== 32'h200) begin
            failures++;
            $display("FAIL flush_redirect_pc: popped=%b pc=%h, required 1 at 00000200", ok, lastInstrPc);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_random();
        int          startPops;
        bit          br;
        logic [31:0] tgt;
        doReset();
        reqRdyRandom   = 1'b1;
        instrRdyRandom = 1'b1;
        latMin = 1;
        latMax = 4;
        startPops = popCount;
        for (int i = 0; i < 3000; i++) begin
            br  = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            cycle(br, tgt);
        end
        asserts++;
        if (popCount - startPops < 100) begin
            failures++;
            $display("FAIL random_progress: %0d instructions consumed, required at least 100", popCount - startPops);
        end
    endtask

    initial begin
        setDefaults();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_with_rsp();
        test_reset_midstream();
        test_redirect_in_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
